// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU issue stage.
package spu_pkg;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 7;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pipe_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD2 = 2'd1,
        HOLD1 = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [0:10]                 op;
        logic [2:0]                  format;
        logic [1:0]                  unit;
        pipe_t                       pipe;
        logic [0:ADDR_W-1]           rt_addr;
        logic [2:0][0:ADDR_W-1]      src_addr;
        logic [2:0]                  src_used;
        logic                        reg_write;
        logic [0:17]                 imm;
    } issue_slot_t;

endpackage

// File: rtl/raw_check.sv
// RAW hazard check for one slot: three sources against both pipe scoreboards
// and the pair issued last cycle.
module raw_check #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 7
) (
    input  logic [2:0][0:ADDR_W-1]      src_addr,
    input  logic [2:0]                  src_used,
    input  logic [DEPTH-1:0][0:ADDR_W-1] ev_addr_delay,
    input  logic [DEPTH-1:0][0:ADDR_W-1] od_addr_delay,
    input  logic [DEPTH-1:0]            ev_write_delay,
    input  logic [DEPTH-1:0]            od_write_delay,
    input  logic [0:ADDR_W-1]           ev_last_rt,
    input  logic [0:ADDR_W-1]           od_last_rt,
    input  logic                        ev_last_write,
    input  logic                        od_last_write,
    output logic                        hazard
);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (src_used[i]) begin
                for (int d = 0; d < DEPTH; d++) begin
                    if (ev_write_delay[d] && (ev_addr_delay[d] == src_addr[i])) hazard = 1'b1;
                    if (od_write_delay[d] && (od_addr_delay[d] == src_addr[i])) hazard = 1'b1;
                end
                if (ev_last_write && (ev_last_rt == src_addr[i])) hazard = 1'b1;
                if (od_last_write && (od_last_rt == src_addr[i])) hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_issue.sv
// Dual-issue stage: holds one decoded pair, resolves hazards and routes each
// slot to the even or odd pipe.
//   state | meaning
//   IDLE  | no held pair
//   HOLD2 | pair held, neither slot issued
//   HOLD1 | slot 0 issued (or invalid), slot 1 pending
module dual_issue #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 7,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_slot_valid,
    input  logic [1:0][0:10]              in_op,
    input  logic [1:0][2:0]               in_format,
    input  logic [1:0][1:0]               in_unit,
    input  logic [1:0]                    in_pipe,
    input  logic [1:0][0:ADDR_W-1]        in_rt_addr,
    input  logic [1:0][2:0][0:ADDR_W-1]   in_src_addr,
    input  logic [1:0][2:0]               in_src_used,
    input  logic [1:0]                    in_reg_write,
    input  logic [1:0][0:17]              in_imm,
    input  logic [PC_W-1:0]               in_pc,
    input  logic [DEPTH-1:0][0:ADDR_W-1]  ev_addr_delay,
    input  logic [DEPTH-1:0][0:ADDR_W-1]  od_addr_delay,
    input  logic [DEPTH-1:0]              ev_write_delay,
    input  logic [DEPTH-1:0]              od_write_delay,
    input  logic                          branch_taken,
    output logic                          ev_valid,
    output logic                          od_valid,
    output logic [0:10]                   ev_op,
    output logic [0:10]                   od_op,
    output logic [2:0]                    ev_format,
    output logic [2:0]                    od_format,
    output logic [1:0]                    ev_unit,
    output logic [1:0]                    od_unit,
    output logic [0:ADDR_W-1]             ev_rt_addr,
    output logic [0:ADDR_W-1]             od_rt_addr,
    output logic                          ev_reg_write,
    output logic                          od_reg_write,
    output logic [0:17]                   ev_imm,
    output logic [0:17]                   od_imm,
    output logic                          od_first,
    output logic [PC_W-1:0]               od_pc,
    output logic [CNT_W-1:0]              stall_count
);
    import spu_pkg::*;

    issue_state_t state;
    issue_slot_t  hold [2];
    issue_slot_t  in_slot [2];
    logic [1:0]   hold_v;
    logic [PC_W-1:0] hold_pc;

    logic [1:0] raw_haz, haz;
    logic conflict, issue0, issue1, done, stall, accept;
    logic ev_sel_v, od_sel_v, ev_idx, od_idx, od_sel_first;
    logic [PC_W-1:0] od_sel_pc;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            in_slot[s].op        = in_op[s];
            in_slot[s].format    = in_format[s];
            in_slot[s].unit      = in_unit[s];
            in_slot[s].pipe      = pipe_t'(in_pipe[s]);
            in_slot[s].rt_addr   = in_rt_addr[s];
            in_slot[s].src_addr  = in_src_addr[s];
            in_slot[s].src_used  = in_src_used[s];
            in_slot[s].reg_write = in_reg_write[s];
            in_slot[s].imm       = in_imm[s];
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_raw
        raw_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_raw (
            .src_addr       (hold[s].src_addr),
            .src_used       (hold[s].src_used),
            .ev_addr_delay  (ev_addr_delay),
            .od_addr_delay  (od_addr_delay),
            .ev_write_delay (ev_write_delay),
            .od_write_delay (od_write_delay),
            .ev_last_rt     (ev_rt_addr),
            .od_last_rt     (od_rt_addr),
            .ev_last_write  (ev_valid & ev_reg_write),
            .od_last_write  (od_valid & od_reg_write),
            .hazard         (raw_haz[s])
        );
    end

    assign haz = raw_haz & hold_v;

    always_comb begin
        conflict = (hold[0].pipe == hold[1].pipe);
        for (int i = 0; i < 3; i++) begin
            if (hold[0].reg_write && hold[1].src_used[i] &&
                (hold[1].src_addr[i] == hold[0].rt_addr)) conflict = 1'b1;
        end
    end

    // HOLD2 always has slot 0 valid; a lone slot 1 is loaded straight into HOLD1.
    always_comb begin
        issue0 = 1'b0;
        issue1 = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE:  done = 1'b1;
            HOLD2: begin
                if (!haz[0]) begin
                    issue0 = 1'b1;
                    if (!hold_v[1]) begin
                        done = 1'b1;
                    end else if (!haz[1] && !conflict) begin
                        issue1 = 1'b1;
                        done   = 1'b1;
                    end
                end
            end
            HOLD1: begin
                if (!haz[1]) begin
                    issue1 = 1'b1;
                    done   = 1'b1;
                end
            end
            default: ;
        endcase
        if (branch_taken) begin
            issue0 = 1'b0;
            issue1 = 1'b0;
        end
    end

    assign in_ready = reset & ~branch_taken & done;
    assign accept   = in_valid & in_ready;
    assign stall    = (state != IDLE) & ~issue0 & ~issue1 & ~branch_taken;

    always_comb begin
        ev_sel_v = 1'b0;
        ev_idx   = 1'b0;
        od_sel_v = 1'b0;
        od_idx   = 1'b0;
        if (issue0) begin
            if (hold[0].pipe == EVEN) ev_sel_v = 1'b1;
            else                      od_sel_v = 1'b1;
        end
        if (issue1) begin
            if (hold[1].pipe == EVEN) begin
                ev_sel_v = 1'b1;
                ev_idx   = 1'b1;
            end else begin
                od_sel_v = 1'b1;
                od_idx   = 1'b1;
            end
        end
        od_sel_first = od_sel_v & ~od_idx & (issue1 | ~hold_v[1]);
        od_sel_pc    = od_sel_v ? hold_pc + PC_W'(od_idx) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hold[0]      <= '0;
            hold[1]      <= '0;
            hold_v       <= '0;
            hold_pc      <= '0;
            ev_valid     <= 1'b0;
            ev_op        <= '0;
            ev_format    <= '0;
            ev_unit      <= '0;
            ev_rt_addr   <= '0;
            ev_reg_write <= 1'b0;
            ev_imm       <= '0;
            od_valid     <= 1'b0;
            od_op        <= '0;
            od_format    <= '0;
            od_unit      <= '0;
            od_rt_addr   <= '0;
            od_reg_write <= 1'b0;
            od_imm       <= '0;
            od_first     <= 1'b0;
            od_pc        <= '0;
            stall_count  <= '0;
        end else begin
            ev_valid     <= ev_sel_v;
            ev_op        <= ev_sel_v ? hold[ev_idx].op        : '0;
            ev_format    <= ev_sel_v ? hold[ev_idx].format    : '0;
            ev_unit      <= ev_sel_v ? hold[ev_idx].unit      : '0;
            ev_rt_addr   <= ev_sel_v ? hold[ev_idx].rt_addr   : '0;
            ev_reg_write <= ev_sel_v & hold[ev_idx].reg_write;
            ev_imm       <= ev_sel_v ? hold[ev_idx].imm       : '0;
            od_valid     <= od_sel_v;
            od_op        <= od_sel_v ? hold[od_idx].op        : '0;
            od_format    <= od_sel_v ? hold[od_idx].format    : '0;
            od_unit      <= od_sel_v ? hold[od_idx].unit      : '0;
            od_rt_addr   <= od_sel_v ? hold[od_idx].rt_addr   : '0;
            od_reg_write <= od_sel_v & hold[od_idx].reg_write;
            od_imm       <= od_sel_v ? hold[od_idx].imm       : '0;
            od_first     <= od_sel_first;
            od_pc        <= od_sel_pc;

            if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);

            if (branch_taken) begin
                state  <= IDLE;
                hold_v <= '0;
            end else if (accept) begin
                hold[0] <= in_slot[0];
                hold[1] <= in_slot[1];
                hold_v  <= in_slot_valid;
                hold_pc <= in_pc;
                if (in_slot_valid[0])      state <= HOLD2;
                else if (in_slot_valid[1]) state <= HOLD1;
                else                       state <= IDLE;
            end else if (done) begin
                state  <= IDLE;
                hold_v <= '0;
            end else if ((state == HOLD2) && issue0) begin
                state     <= HOLD1;
                hold_v[0] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue.sv
// Bench for dual_issue: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based issue model.
module tb_dual_issue;
    localparam int AW = 7;
    localparam int D  = 7;
    localparam int PW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid, in_ready, branch_taken;
    logic [1:0]            in_slot_valid, in_pipe, in_reg_write;
    logic [1:0][0:10]      in_op;
    logic [1:0][2:0]       in_format, in_src_used;
    logic [1:0][1:0]       in_unit;
    logic [1:0][0:AW-1]    in_rt_addr;
    logic [1:0][2:0][0:AW-1] in_src_addr;
    logic [1:0][0:17]      in_imm;
    logic [PW-1:0]         in_pc;
    logic [D-1:0][0:AW-1]  ev_addr_delay, od_addr_delay;
    logic [D-1:0]          ev_write_delay, od_write_delay;
    logic                  ev_valid, od_valid, ev_reg_write, od_reg_write, od_first;
    logic [0:10]           ev_op, od_op;
    logic [2:0]            ev_format, od_format;
    logic [1:0]            ev_unit, od_unit;
    logic [0:AW-1]         ev_rt_addr, od_rt_addr;
    logic [0:17]           ev_imm, od_imm;
    logic [PW-1:0]         od_pc;
    logic [CW-1:0]         stall_count;

    dual_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_slot_valid(in_slot_valid), .in_op(in_op), .in_format(in_format),
        .in_unit(in_unit), .in_pipe(in_pipe), .in_rt_addr(in_rt_addr),
        .in_src_addr(in_src_addr), .in_src_used(in_src_used),
        .in_reg_write(in_reg_write), .in_imm(in_imm), .in_pc(in_pc),
        .ev_addr_delay(ev_addr_delay), .od_addr_delay(od_addr_delay),
        .ev_write_delay(ev_write_delay), .od_write_delay(od_write_delay),
        .branch_taken(branch_taken), .ev_valid(ev_valid), .od_valid(od_valid),
        .ev_op(ev_op), .od_op(od_op), .ev_format(ev_format), .od_format(od_format),
        .ev_unit(ev_unit), .od_unit(od_unit), .ev_rt_addr(ev_rt_addr),
        .od_rt_addr(od_rt_addr), .ev_reg_write(ev_reg_write),
        .od_reg_write(od_reg_write), .ev_imm(ev_imm), .od_imm(od_imm),
        .od_first(od_first), .od_pc(od_pc), .stall_count(stall_count)
    );

    typedef struct {
        logic [0:10] op; logic [2:0] fmt; logic [1:0] unit; logic pipe;
        logic [0:AW-1] rt; logic [2:0][0:AW-1] src; logic [2:0] used; logic wr;
        logic [0:17] imm; logic [PW-1:0] pc; int idx;
    } ent_t;

    typedef struct packed {
        logic ev_v; logic [0:10] ev_op; logic [2:0] ev_fmt; logic [1:0] ev_unit;
        logic [0:AW-1] ev_rt; logic ev_wr; logic [0:17] ev_imm;
        logic od_v; logic [0:10] od_op; logic [2:0] od_fmt; logic [1:0] od_unit;
        logic [0:AW-1] od_rt; logic od_wr; logic [0:17] od_imm;
        logic od_first; logic [PW-1:0] od_pc; logic [CW-1:0] sc;
    } out_t;

    typedef struct { int sv, p0, p1, rt0, wr0, s1a, u1a, pc, ev, od, first, opc; } vec_t;

    ent_t pend[$];
    out_t exp_o;
    bit   m_iss0, m_iss1, m_ready;
    int   n_tests = 0, n_fail = 0;
    vec_t vecs[11];
    logic [CW-1:0] sc0;

    task automatic check(string name, logic [127:0] act, logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic out_t get_act();
        out_t a;
        a.ev_v = ev_valid; a.ev_op = ev_op; a.ev_fmt = ev_format; a.ev_unit = ev_unit;
        a.ev_rt = ev_rt_addr; a.ev_wr = ev_reg_write; a.ev_imm = ev_imm;
        a.od_v = od_valid; a.od_op = od_op; a.od_fmt = od_format; a.od_unit = od_unit;
        a.od_rt = od_rt_addr; a.od_wr = od_reg_write; a.od_imm = od_imm;
        a.od_first = od_first; a.od_pc = od_pc; a.sc = stall_count;
        return a;
    endfunction

    // An instruction may go when none of its read registers is still in flight.
    function automatic bit blocked(ent_t e);
        for (int i = 0; i < 3; i++) begin
            if (e.used[i]) begin
                for (int d = 0; d < D; d++) begin
                    if (ev_write_delay[d] && ev_addr_delay[d] == e.src[i]) return 1'b1;
                    if (od_write_delay[d] && od_addr_delay[d] == e.src[i]) return 1'b1;
                end
                if (exp_o.ev_v && exp_o.ev_wr && exp_o.ev_rt == e.src[i]) return 1'b1;
                if (exp_o.od_v && exp_o.od_wr && exp_o.od_rt == e.src[i]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit pair_conflict(ent_t a, ent_t b);
        if (a.pipe == b.pipe) return 1'b1;
        for (int i = 0; i < 3; i++)
            if (a.wr && b.used[i] && b.src[i] == a.rt) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_eval();
        bit all_done;
        m_iss0 = 1'b0;
        m_iss1 = 1'b0;
        if (pend.size() > 0 && !branch_taken && !blocked(pend[0])) begin
            m_iss0 = 1'b1;
            if (pend.size() > 1 && !blocked(pend[1]) && !pair_conflict(pend[0], pend[1]))
                m_iss1 = 1'b1;
        end
        all_done = (pend.size() == 0) || (m_iss0 && (pend.size() == 1 || m_iss1));
        m_ready  = !branch_taken && all_done;
    endfunction

    function automatic void model_update();
        out_t nx;
        ent_t e;
        int n;
        n = int'(m_iss0) + int'(m_iss1);
        nx = '0;
        nx.sc = exp_o.sc;
        if (pend.size() > 0 && !m_iss0 && !branch_taken && nx.sc != '1) nx.sc = nx.sc + 1'b1;
        for (int k = 0; k < n; k++) begin
            e = pend[k];
            if (!e.pipe) begin
                nx.ev_v = 1'b1; nx.ev_op = e.op; nx.ev_fmt = e.fmt; nx.ev_unit = e.unit;
                nx.ev_rt = e.rt; nx.ev_wr = e.wr; nx.ev_imm = e.imm;
            end else begin
                nx.od_v = 1'b1; nx.od_op = e.op; nx.od_fmt = e.fmt; nx.od_unit = e.unit;
                nx.od_rt = e.rt; nx.od_wr = e.wr; nx.od_imm = e.imm; nx.od_pc = e.pc;
                nx.od_first = (e.idx == 0) && (pend.size() == 1 || m_iss1);
            end
        end
        for (int k = 0; k < n; k++) void'(pend.pop_front());
        if (branch_taken) pend.delete();
        else if (in_valid && m_ready) begin
            for (int s = 0; s < 2; s++) begin
                if (in_slot_valid[s]) begin
                    e.op = in_op[s]; e.fmt = in_format[s]; e.unit = in_unit[s];
                    e.pipe = in_pipe[s]; e.rt = in_rt_addr[s]; e.src = in_src_addr[s];
                    e.used = in_src_used[s]; e.wr = in_reg_write[s]; e.imm = in_imm[s];
                    e.pc = in_pc + PW'(s); e.idx = s;
                    pend.push_back(e);
                end
            end
        end
        exp_o = nx;
    endfunction

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        model_eval();
        check("in_ready", 128'(in_ready), 128'(m_ready));
        @(posedge clk);
        #1;
        model_update();
        check("outputs", 128'(get_act()), 128'(exp_o));
        @(negedge clk);
    endtask

    task automatic clear_sb();
        ev_addr_delay = '0; od_addr_delay = '0; ev_write_delay = '0; od_write_delay = '0;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; in_slot_valid = '0; in_op = '0; in_format = '0; in_unit = '0;
        in_pipe = '0; in_rt_addr = '0; in_src_addr = '0; in_src_used = '0;
        in_reg_write = '0; in_imm = '0; in_pc = '0; branch_taken = 1'b0;
        clear_sb();
    endtask

    task automatic set_slot(int s, int pipe, int rt, int wr, int a, int b, int c, int used);
        in_pipe[s] = 1'(pipe); in_rt_addr[s] = AW'(rt); in_reg_write[s] = 1'(wr);
        in_src_addr[s][0] = AW'(a); in_src_addr[s][1] = AW'(b); in_src_addr[s][2] = AW'(c);
        in_src_used[s] = 3'(used);
        in_op[s] = 11'($urandom); in_format[s] = 3'($urandom);
        in_unit[s] = 2'($urandom); in_imm[s] = 18'($urandom);
    endtask

    task automatic drain(int n);
        in_valid = 1'b0; branch_taken = 1'b0; clear_sb();
        repeat (n) tick();
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 128'(get_act()), 128'(0));
        check("reset_ready", 128'(in_ready), 128'(0));
        exp_o = '0;
        @(negedge clk);
        reset = 1'b1;

        //        sv p0 p1 rt0 wr0 s1a u1a pc   ev od first opc
        vecs[0]  = '{3, 0, 1, 3, 1, 1, 1, 10,  1, 1, 0, 11};
        vecs[1]  = '{3, 1, 0, 3, 1, 1, 1, 20,  1, 1, 1, 20};
        vecs[2]  = '{3, 0, 0, 3, 1, 1, 1, 25,  1, 0, 0, 0};
        vecs[3]  = '{3, 1, 1, 3, 1, 1, 1, 30,  0, 1, 0, 30};
        vecs[4]  = '{1, 1, 0, 3, 1, 1, 1, 40,  0, 1, 1, 40};
        vecs[5]  = '{2, 0, 1, 3, 1, 1, 1, 255, 0, 1, 0, 0};
        vecs[6]  = '{0, 0, 1, 3, 1, 1, 1, 45,  0, 0, 0, 0};
        vecs[7]  = '{3, 0, 1, 5, 1, 5, 1, 50,  1, 0, 0, 0};
        vecs[8]  = '{3, 0, 1, 5, 0, 5, 1, 50,  1, 1, 0, 51};
        vecs[9]  = '{3, 0, 1, 5, 1, 5, 0, 50,  1, 1, 0, 51};
        vecs[10] = '{1, 0, 1, 3, 1, 1, 1, 60,  1, 0, 0, 0};

        foreach (vecs[i]) begin
            set_slot(0, vecs[i].p0, vecs[i].rt0, vecs[i].wr0, 10, 11, 12, 7);
            set_slot(1, vecs[i].p1, 4, 1, vecs[i].s1a, 13, 14, 6 | vecs[i].u1a);
            in_pc = PW'(vecs[i].pc);
            in_slot_valid = 2'(vecs[i].sv);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            check($sformatf("vec%0d", i), 128'({ev_valid, od_valid, od_first, od_pc}),
                  128'({1'(vecs[i].ev), 1'(vecs[i].od), 1'(vecs[i].first), PW'(vecs[i].opc)}));
            drain(4);
        end

        // Slot 1 reads slot 0's result: split issue, one stall on last-issue.
        set_slot(0, 0, 5, 1, 10, 11, 12, 7);
        set_slot(1, 1, 6, 1, 5, 13, 14, 1);
        in_pc = 8'd70; in_slot_valid = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sc0 = exp_o.sc;
        tick(); check("raw_slot0_alone", 128'({ev_valid, od_valid}), 128'(2'b10));
        tick(); check("raw_bubble", 128'({ev_valid, od_valid}), 128'(2'b00));
        tick(); check("raw_slot1", 128'({ev_valid, od_valid}), 128'(2'b01));
        check("raw_stall_count", 128'(stall_count), 128'(sc0 + 1'b1));
        drain(3);

        // Odd scoreboard entry blocks slot 0 until it retires.
        set_slot(0, 0, 20, 1, 30, 9, 31, 7);
        set_slot(1, 1, 21, 0, 32, 33, 34, 7);
        od_write_delay[3] = 1'b1; od_addr_delay[3] = 7'd9;
        in_pc = 8'd80; in_slot_valid = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sc0 = exp_o.sc;
        repeat (3) begin
            tick();
            check("sb_stall", 128'({ev_valid, od_valid}), 128'(2'b00));
        end
        check("sb_stall_count", 128'(stall_count), 128'(sc0 + 16'd3));
        od_write_delay = '0;
        tick();
        check("sb_resume", 128'({ev_valid, od_valid}), 128'(2'b11));
        drain(3);

        // Taken branch while stalled discards the held pair and the offered one.
        set_slot(0, 0, 20, 1, 30, 9, 31, 7);
        set_slot(1, 1, 21, 0, 32, 33, 34, 7);
        od_write_delay[3] = 1'b1; od_addr_delay[3] = 7'd9;
        in_slot_valid = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        branch_taken = 1'b1; in_valid = 1'b1;
        #1;
        check("branch_ready", 128'(in_ready), 128'(0));
        tick();
        check("branch_kill", 128'({ev_valid, od_valid}), 128'(2'b00));
        branch_taken = 1'b0; in_valid = 1'b0; clear_sb();
        repeat (3) begin
            tick();
            check("branch_no_issue", 128'({ev_valid, od_valid}), 128'(2'b00));
        end

        // PC wrap on slot 1.
        set_slot(0, 0, 40, 1, 41, 42, 43, 7);
        set_slot(1, 1, 44, 1, 45, 46, 47, 7);
        in_pc = 8'd255; in_slot_valid = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("pc_wrap", 128'({od_valid, od_first, od_pc}), 128'({1'b1, 1'b0, 8'd0}));
        drain(3);

        // Reset while slot 1 is still pending in HOLD1.
        set_slot(0, 0, 50, 1, 51, 52, 53, 7);
        set_slot(1, 0, 54, 1, 55, 56, 57, 7);
        in_slot_valid = 2'b11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("mid_reset_outputs", 128'(get_act()), 128'(0));
        check("mid_reset_ready", 128'(in_ready), 128'(0));
        pend.delete();
        exp_o = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            tick();
            check("mid_reset_lost", 128'({ev_valid, od_valid}), 128'(2'b00));
        end

        // Randomized traffic against the model.
        for (int t = 0; t < 800; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_slot_valid = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            for (int s = 0; s < 2; s++)
                set_slot(s, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)));
            in_pc = 8'($urandom);
            for (int d = 0; d < D; d++) begin
                ev_write_delay[d] = ($urandom_range(0, 11) == 0);
                od_write_delay[d] = ($urandom_range(0, 11) == 0);
                ev_addr_delay[d]  = AW'($urandom_range(0, 7));
                od_addr_delay[d]  = AW'($urandom_range(0, 7));
            end
            branch_taken = ($urandom_range(0, 19) == 0);
            tick();
        end
        drain(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_issue.md
Name: dual_issue

Overview:
- Issue stage directly upstream of the even pipe and the odd pipe (permute/local-store/branch).
- Accepts a decoded instruction pair from decode, checks structural and RAW hazards, and routes each slot to its pipe.
- RAW checks cover intra-pair dependencies, the delay scoreboards exported by both pipes, and the pair issued last cycle.
- Issues both slots, one slot, or stalls; flushes held work on a taken branch.

Parameters:
ADDR_W, 7, register address width
DEPTH, 7, scoreboard stages exported by each pipe
PC_W, 8, program counter width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents a pair
in_ready  out  1  pair accepted this cycle when in_valid & in_ready
in_slot_valid  in  [1:0]  slot holds a real instr (0 = first in program order)
in_op  in  [1:0][0:10]  decoded opcode per slot
in_format  in  [1:0][2:0]  format per slot
in_unit  in  [1:0][1:0]  execution unit per slot
in_pipe  in  [1:0]  0 even, 1 odd
in_rt_addr  in  [1:0][0:ADDR_W-1]  destination
in_src_addr  in  [1:0][2:0][0:ADDR_W-1]  ra, rb, rc/rt_st source addresses
in_src_used  in  [1:0][2:0]  source actually read
in_reg_write  in  [1:0]  slot writes RF
in_imm  in  [1:0][0:17]  immediate
in_pc  in  PC_W  PC of slot 0; slot 1 is in_pc+1
ev_addr_delay, od_addr_delay  in  [DEPTH-1:0][0:ADDR_W-1]  in-flight destinations per pipe
ev_write_delay, od_write_delay  in  [DEPTH-1:0]  entry valid
branch_taken  in  1  odd pipe resolved a taken branch
ev_valid, od_valid  out  1  registered issue strobe per pipe
ev_op, od_op  out  [0:10]; ev_format, od_format out [2:0]; ev_unit, od_unit out [1:0]
ev_rt_addr, od_rt_addr  out  [0:ADDR_W-1]; ev_reg_write, od_reg_write out 1; ev_imm, od_imm out [0:17]
od_first  out  1  odd instr was slot 0 of its pair
od_pc  out  PC_W  PC of issued odd instr
stall_count  out  CNT_W  cycles with held work and nothing issued, saturating

Behaviour:
- Reset (reset low): state IDLE; all valids, payloads, od_first, od_pc and stall_count are 0; in_ready is 0 while reset is asserted.
- States:
  - IDLE: no held pair.
  - HOLD2: pair held, neither slot issued.
  - HOLD1: slot 0 issued, slot 1 pending.
- in_ready rule: asserted in IDLE, or when the held work fully issues this cycle (back-to-back throughput).
- An accepted pair is registered into the hold buffer. It is evaluated the next cycle.
- Slot hazard: any used source equals a valid ev/od delay entry, or equals the rt_addr of last cycle's issued ev/od instr with reg_write=1.
- Pair conflict:
  - both slots target the same pipe, or
  - slot 1 reads slot 0's destination while slot 0 has reg_write=1.
- HOLD2 decisions:
  - Neither slot hazarded, no pair conflict: issue both, go to IDLE.
  - Otherwise, slot 0 clear: issue slot 0 only, go to HOLD1.
  - Otherwise: stall.
- HOLD1: issue slot 1 when it is clear, then go to IDLE.
- Invalid slots (in_slot_valid=0) never issue, never hazard, and are treated as already issued. A pair with both slots invalid is dropped on acceptance.
- Issue outputs are registered, with one cycle from decision to ev_/od_valid. Outputs hold payload only while valid; valid is 0 otherwise.
- od_first = 1 iff the odd instr is slot 0 and slot 1 is dual-issued with it, or slot 1 is invalid.
- od_pc = in_pc + slot index, modulo 2^PC_W (wraps at 255→0).
- branch_taken:
  - Discard the hold buffer and any pair accepted that cycle; go to IDLE.
  - Force ev_valid/od_valid to 0 on the next edge; in_ready is 0 that cycle.
  - branch_taken takes priority over a simultaneous issue decision.
- stall_count increments in HOLD1/HOLD2 when nothing issues and branch_taken=0. It saturates at all-ones and clears only on reset.
- Asynchronous reset mid-HOLD: held work is lost and the state returns to IDLE.

Decomposition:
- Shared package spu_pkg holds:
  - pipe enum (EVEN, ODD);
  - issue state enum (IDLE, HOLD2, HOLD1);
  - packed struct issue_slot_t (op, format, unit, pipe, rt_addr, src_addr, src_used, reg_write, imm);
  - constants ADDR_W and DEPTH.
- One natural sub-module: raw_check. It compares one slot's three sources against 2×DEPTH scoreboard entries plus two last-issue entries, and is instantiated once per slot.

Test Plan:
- Slot 0 even add rt=3, slot 1 odd load rt=4, independent sources, empty scoreboards -> next cycle ev_valid=od_valid=1, od_first=0, od_pc=in_pc+1, in_ready stays 1.
- Slot 0 rt=5 reg_write=1, slot 1 reads ra=5 -> slot 0 issues alone, state HOLD1; slot 1 issues the cycle after last-issue clears (scoreboards empty); stall_count unchanged if slot 1 issues next cycle.
- Both slots target even -> slot 0 issues first, slot 1 issues the following cycle.
- od_write_delay[3]=1 with od_addr_delay[3]=9 and slot 0 reads rb=9 -> no issue, stall_count increments each cycle, and issue resumes the cycle the entry clears.
- In HOLD2 with a stall, pulse branch_taken -> next cycle valids are 0, state IDLE, the held pair never issues.
- in_pc=255 with slot 1 odd -> od_pc=0; assert reset low mid-HOLD1 -> all outputs 0 immediately, stall_count=0.
